// File: rtl/ber_checker.sv
// ber_checker: decimate + BPSK slice, exhaustive PRBS delay search, then bit/error counting.
// Delay d pairs the decision of strobe k with the reference bit of strobe k-d. Optional relock: BER_RELOCK_EN.
module ber_checker #(
   parameter int NBT_IN     = 8,
   parameter int OS         = 4,
   parameter int PRBS_LEN   = 511,
   parameter int SEARCH_WIN = 511,
   parameter int NB_CNT     = 64
`ifdef BER_RELOCK_EN
   , parameter int RELOCK_THR = 64
`endif
) (
   input  logic                  clk,
   input  logic                  i_reset,
   input  logic                  i_en,
   input  logic [NBT_IN-1:0]     i_is_data,
   input  logic [$clog2(OS)-1:0] i_phase,
   input  logic                  i_ref_bit,
   output logic                  o_bit,
   output logic                  o_bit_valid,
   output logic                  o_locked,
   output logic [8:0]            o_delay,
   output logic [NB_CNT-1:0]     o_bit_cnt,
   output logic [NB_CNT-1:0]     o_err_cnt
);
   localparam int AW = $clog2(PRBS_LEN);
   localparam int WW = $clog2(SEARCH_WIN + 1);
   typedef enum logic [1:0] {FILL, SEARCH, LOCK} state_t;
   state_t state, state_nx;
   logic [$clog2(OS)-1:0] pc;
   logic [PRBS_LEN-1:0] ref_buf, ref_new;
   logic [8:0] d, best_d, best_nx;
   logic [WW-1:0] win_cnt, win_err, min_err, win_sum;
   logic strobe, sliced, mis, win_end, last_d, better, relock;
   logic unused_lsbs;
   assign unused_lsbs = ^i_is_data[NBT_IN-2:0];
   assign strobe  = i_en && pc == i_phase;
   assign sliced  = i_is_data[NBT_IN-1];
   // Comparison sees the buffer as it will be after this strobe's shift, so ref[0] is the current i_ref_bit.
   assign ref_new = {ref_buf[PRBS_LEN-2:0], i_ref_bit};
   assign mis     = sliced != ref_new[d[AW-1:0]];
   assign win_sum = win_err + WW'(mis);
   assign win_end = win_cnt == WW'(SEARCH_WIN - 1);
   assign last_d  = d == 9'(PRBS_LEN - 1);
   assign better  = win_sum < min_err;
   assign best_nx = better ? d : best_d;
   assign o_locked = state == LOCK;
`ifdef BER_RELOCK_EN
   assign relock = win_end && win_sum > WW'(RELOCK_THR);
`else
   assign relock = 1'b0;
`endif
   always_comb begin
      state_nx = state;
      if (strobe)
         state_nx = (state == FILL && last_d) ? SEARCH :
                    (state == SEARCH && win_end && last_d) ? LOCK :
                    (state == LOCK && relock) ? SEARCH : state;
   end
   always_ff @(posedge clk)
      if (i_reset) state <= FILL;
      else if (i_en) state <= state_nx;
   always_ff @(posedge clk) begin
      if (i_reset) begin
         pc          <= '0;
         ref_buf     <= '0;
         d           <= '0;
         best_d      <= '0;
         win_cnt     <= '0;
         win_err     <= '0;
         min_err     <= '0;
         o_bit       <= 1'b0;
         o_bit_valid <= 1'b0;
         o_delay     <= '0;
         o_bit_cnt   <= '0;
         o_err_cnt   <= '0;
      end else begin
         o_bit_valid <= strobe;
         if (i_en) pc <= pc + 1'b1;
         if (strobe) begin
            o_bit   <= sliced;
            ref_buf <= ref_new;
            if (state == FILL) begin
               d       <= last_d ? '0 : d + 1'b1;
               best_d  <= '0;
               win_cnt <= '0;
               win_err <= '0;
               min_err <= '1;
            end else if (state == SEARCH) begin
               win_cnt <= win_end ? '0 : win_cnt + 1'b1;
               win_err <= win_end ? '0 : win_sum;
               if (win_end) begin
                  if (better) begin
                     min_err <= win_sum;
                     best_d  <= d;
                  end
                  d <= last_d ? best_nx : d + 1'b1;
                  if (last_d) begin
                     o_delay   <= best_nx;
                     o_bit_cnt <= '0;
                     o_err_cnt <= '0;
                  end
               end
            end else begin
               // In LOCK, d holds the chosen delay so the same reference mux serves both phases.
               o_bit_cnt <= o_bit_cnt + NB_CNT'(o_bit_cnt != '1);
               o_err_cnt <= o_err_cnt + NB_CNT'(mis && o_err_cnt != '1);
`ifdef BER_RELOCK_EN
               win_cnt <= win_end ? '0 : win_cnt + 1'b1;
               win_err <= win_end ? '0 : win_sum;
               if (relock) begin
                  d       <= '0;
                  best_d  <= '0;
                  min_err <= '1;
               end
`endif
            end
         end
      end
   end
endmodule
